// File: rtl/rbm_mem_window.sv
// CPU-side window into the four RBM banks: one-deep posted write buffer plus a cached read-back.
// Writes win over reads; the window stalls in IDLE while the engine owns the banks.
module rbm_mem_window #(
   parameter int BANK_AW = 12
) (
   input  logic               ACLK,
   input  logic               ARESETn,
   input  logic [31:0]        mem_addr,
   input  logic [31:0]        mem_wdata,
   input  logic               mem_wen,
   input  logic [2:0]         mem_sel,
   output logic [31:0]        mem_rdata,
   input  logic               eng_busy,
   output logic [3:0]         bank_en,
   output logic               bank_we,
   output logic [BANK_AW-1:0] bank_addr,
   output logic [31:0]        bank_wdata,
   input  logic [127:0]       bank_rdata,
   output logic               rd_valid,
   output logic [2:0]         err_flags,
   input  logic               err_clr,
   output logic [15:0]        wr_count
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WR     = 2'd1;
   localparam logic [1:0] S_RD_REQ = 2'd2;
   localparam logic [1:0] S_RD_CAP = 2'd3;

   logic [1:0]         state_q, state_d;
   logic               pend_v_q, pend_v_d;
   logic [1:0]         pend_sel_q, pend_sel_d;
   logic [BANK_AW-1:0] pend_idx_q, pend_idx_d;
   logic [31:0]        pend_wdata_q, pend_wdata_d;
   logic [2:0]         lat_sel_q, lat_sel_d;
   logic [31:0]        lat_addr_q, lat_addr_d;
   logic               rd_bad_q, rd_bad_d;
   logic               dirty_q, dirty_d;
   logic [2:0]         err_q, err_d;
   logic [15:0]        wr_count_q, wr_count_d;
   logic [31:0]        mem_rdata_q, mem_rdata_d;
   logic [2:0]         err_set;

   logic [BANK_AW-1:0] cur_idx;
   logic [BANK_AW-1:0] lat_idx;
   logic               sel_bad;
   logic               addr_oor;
   logic               tgt_chg;
   logic               dirty_eff;

   assign cur_idx   = mem_addr[BANK_AW+1:2];
   assign lat_idx   = lat_addr_q[BANK_AW+1:2];
   assign sel_bad   = mem_sel[2];
   assign addr_oor  = |(mem_addr >> (BANK_AW + 2));
   // A target change is visible combinationally so IDLE reacts in the same cycle.
   assign tgt_chg   = (mem_sel != lat_sel_q) || (mem_addr != lat_addr_q);
   assign dirty_eff = dirty_q | tgt_chg;

   always_comb begin
      state_d      = state_q;
      pend_v_d     = pend_v_q;
      pend_sel_d   = pend_sel_q;
      pend_idx_d   = pend_idx_q;
      pend_wdata_d = pend_wdata_q;
      lat_sel_d    = lat_sel_q;
      lat_addr_d   = lat_addr_q;
      rd_bad_d     = rd_bad_q;
      dirty_d      = dirty_eff;
      wr_count_d   = wr_count_q;
      mem_rdata_d  = mem_rdata_q;
      err_set      = 3'b000;
      bank_en      = 4'b0000;
      bank_we      = 1'b0;
      bank_addr    = '0;
      bank_wdata   = 32'h0;

      case (state_q)
         S_IDLE: begin
            if (!eng_busy) begin
               if (pend_v_q)       state_d = S_WR;
               else if (dirty_eff) state_d = S_RD_REQ;
            end
         end
         S_WR: begin
            bank_en    = 4'b0001 << pend_sel_q;
            bank_we    = 1'b1;
            bank_addr  = pend_idx_q;
            bank_wdata = pend_wdata_q;
            pend_v_d   = 1'b0;
            wr_count_d = wr_count_q + 16'd1;
            if (({1'b0, pend_sel_q} == lat_sel_q) && (pend_idx_q == lat_idx)) dirty_d = 1'b1;
            state_d    = S_IDLE;
         end
         S_RD_REQ: begin
            lat_sel_d  = mem_sel;
            lat_addr_d = mem_addr;
            rd_bad_d   = sel_bad | addr_oor;
            err_set    = err_set | {1'b0, addr_oor, sel_bad};
            if (!(sel_bad | addr_oor)) begin
               bank_en   = 4'b0001 << mem_sel[1:0];
               bank_addr = cur_idx;
            end
            dirty_d    = 1'b0;
            state_d    = S_RD_CAP;
         end
         default: begin
            mem_rdata_d = rd_bad_q ? 32'h0 : bank_rdata[{lat_sel_q[1:0], 5'b00000} +: 32];
            state_d     = S_IDLE;
         end
      endcase

      // Capture happens after the FSM so a write landing in the WR cycle refills the buffer.
      if (mem_wen) begin
         if (sel_bad | addr_oor) begin
            err_set = err_set | {1'b0, addr_oor, sel_bad};
         end else if (pend_v_q && (state_q != S_WR)) begin
            err_set[2] = 1'b1;
         end else begin
            pend_v_d     = 1'b1;
            pend_sel_d   = mem_sel[1:0];
            pend_idx_d   = cur_idx;
            pend_wdata_d = mem_wdata;
         end
      end

      err_d = (err_clr ? 3'b000 : err_q) | err_set;
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q      <= S_IDLE;
         pend_v_q     <= 1'b0;
         pend_sel_q   <= 2'd0;
         pend_idx_q   <= '0;
         pend_wdata_q <= 32'h0;
         lat_sel_q    <= 3'd0;
         lat_addr_q   <= 32'h0;
         rd_bad_q     <= 1'b0;
         dirty_q      <= 1'b1;
         err_q        <= 3'b000;
         wr_count_q   <= 16'h0;
         mem_rdata_q  <= 32'h0;
      end else begin
         state_q      <= state_d;
         pend_v_q     <= pend_v_d;
         pend_sel_q   <= pend_sel_d;
         pend_idx_q   <= pend_idx_d;
         pend_wdata_q <= pend_wdata_d;
         lat_sel_q    <= lat_sel_d;
         lat_addr_q   <= lat_addr_d;
         rd_bad_q     <= rd_bad_d;
         dirty_q      <= dirty_d;
         err_q        <= err_d;
         wr_count_q   <= wr_count_d;
         mem_rdata_q  <= mem_rdata_d;
      end
   end

   assign mem_rdata = mem_rdata_q;
   assign rd_valid  = (state_q == S_IDLE) && !dirty_eff;
   assign err_flags = err_q;
   assign wr_count  = wr_count_q;

endmodule

// File: doc/rbm_mem_window.md
RBM_MEM_WINDOW -- requirements
Module: rbm_mem_window

Interface
REQ-001 SHALL have parameter BANK_AW, default 12, meaning the word-address width of each on-chip bank.
REQ-002 SHALL have port ACLK, input, 1 bit: the single clock; every flop is clocked on its rising edge.
REQ-003 SHALL have port ARESETn, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port mem_addr, input, 32 bits: window byte address from the control register file.
REQ-005 SHALL have port mem_wdata, input, 32 bits: window write data, valid in the same cycle as mem_wen.
REQ-006 SHALL have port mem_wen, input, 1 bit: single-cycle window write strobe.
REQ-007 SHALL have port mem_sel, input, 3 bits: bank select (0=W, 1=b_vis, 2=b_hid, 3=data; 4-7 invalid).
REQ-008 SHALL have port mem_rdata, output, 32 bits: registered read-back of the bank word at mem_sel/mem_addr.
REQ-009 SHALL have port eng_busy, input, 1 bit: RBM engine owns the banks; the window is stalled while it is 1.
REQ-010 SHALL have port bank_en, output, 4 bits: one-hot bank enable.
REQ-011 SHALL have port bank_we, output, 1 bit: write enable qualified by bank_en.
REQ-012 SHALL have port bank_addr, output, BANK_AW bits: bank word address.
REQ-013 SHALL have port bank_wdata, output, 32 bits: bank write data.
REQ-014 SHALL have port bank_rdata, input, 4x32 bits (bank n at [32n+31:32n]): bank read data, valid 1 cycle after an enabled read.
REQ-015 SHALL have port rd_valid, output, 1 bit: mem_rdata matches the current mem_sel/mem_addr.
REQ-016 SHALL have port err_flags, output, 3 bits: sticky errors; bit0 bad sel, bit1 address out of range, bit2 pending-write overflow.
REQ-017 SHALL have port err_clr, input, 1 bit: clears err_flags.
REQ-018 SHALL have port wr_count, output, 16 bits: count of bank writes committed, wraps at 0xFFFF.

Function
REQ-019 SHALL decode word index = mem_addr[BANK_AW+1:2]; the address is out of range if mem_addr[31:BANK_AW+2] is nonzero; mem_addr[1:0] is ignored.
REQ-020 SHALL capture mem_sel, word index and mem_wdata into a one-deep pending-write buffer (pend_v=1) on the cycle mem_wen=1.
REQ-021 SHALL drop a write with bad sel or out-of-range address at capture: set err bit0 or bit1, leave pend_v unchanged.
REQ-022 SHALL drop a mem_wen that arrives while pend_v=1 and the FSM is not in WR, and set err bit2; the older pending write is kept.
REQ-023 SHALL use FSM states IDLE, WR, RD_REQ, RD_CAP.
REQ-024 SHALL, in IDLE with eng_busy=0, go to WR if pend_v=1 (writes take priority), otherwise to RD_REQ if dirty=1, otherwise stay in IDLE.
REQ-025 SHALL stay in IDLE while eng_busy=1, with all bank_en low.
REQ-026 SHALL, in WR, drive the matching bank_en one-hot, bank_we=1, bank_addr and bank_wdata from the buffer for exactly 1 cycle, then clear pend_v, increment wr_count and return to IDLE.
REQ-027 SHALL accept a new mem_wen in the WR cycle into the buffer without raising an overflow.
REQ-028 SHALL hold dirty=1 whenever mem_sel or mem_addr differs from the last issued read, or a write hits the last-read bank and word.
REQ-029 SHALL, in RD_REQ, latch the read target, drive bank_en with bank_we=0 for 1 cycle, clear dirty, then go to RD_CAP.
REQ-030 SHALL, in RD_CAP, register bank_rdata of the latched bank into mem_rdata, then return to IDLE.
REQ-031 SHALL give read latency as: dirty seen in IDLE at cycle N, new mem_rdata visible at N+3.
REQ-032 SHALL, for a bad sel or out-of-range read target, issue no bank_en, load mem_rdata=0 and set the matching error bit.
REQ-033 SHALL drive rd_valid = (state==IDLE) AND dirty=0 AND (mem_sel, mem_addr unchanged since the read was latched).
REQ-034 SHALL re-set dirty and re-issue the read if mem_addr changes during RD_REQ or RD_CAP.
REQ-035 SHALL let a new error win over err_clr when both occur in the same cycle.
REQ-036 SHALL finish an FSM in WR, RD_REQ or RD_CAP when eng_busy rises, then hold in IDLE.

Reset
REQ-037 SHALL, on ARESETn=0, immediately clear: mem_rdata=0, bank_en=0, bank_we=0, bank_addr=0, bank_wdata=0, rd_valid=0, err_flags=0, wr_count=0, pend_v=0, state=IDLE, dirty=1.
REQ-038 SHALL lose any pending write on a reset mid-operation, and perform a read of the current target after reset is released.

Verification
REQ-039 SHALL cover: sel=0, addr=0x10, mem_wen with wdata=0xA5A5_0001 -> one WR cycle with bank_en=0001, bank_addr=4, wr_count=1; mem_rdata=0xA5A5_0001 within 3 further cycles.
REQ-040 SHALL cover: eng_busy=1, then a write -> no bank_en while busy; the write commits 1 cycle after eng_busy falls.
REQ-041 SHALL cover: two mem_wen while eng_busy=1 -> err_flags=3'b100; only the first write commits.
REQ-042 SHALL cover: sel=5 read, then sel=2 with addr=1<<(BANK_AW+2) -> err_flags=3'b011, mem_rdata=0, no bank_en pulses.
REQ-043 SHALL cover: mem_addr changed every cycle for 4 cycles, then held -> rd_valid=0 throughout; rd_valid=1 with correct data 3 cycles after the last change.
REQ-044 SHALL cover: ARESETn asserted during RD_CAP -> all outputs 0 asynchronously; a fresh read completes after release.
